// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG entropy harvester.
package trng_pkg;

  typedef enum logic [1:0] {
    MODE_RAW     = 2'd0,
    MODE_VN      = 2'd1,
    MODE_VN_WHT  = 2'd2,
    MODE_RAW_WHT = 2'd3
  } mode_e;

  localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;

  // Widest ring vector the reduction helper accepts; callers zero-extend.
  localparam int MAX_RINGS = 64;

  function automatic logic xor_reduce(input logic [MAX_RINGS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// Small synchronous FIFO holding harvested words; push while full is accepted
// only when a pop happens in the same cycle.
module trng_fifo import trng_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LEVEL);
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; reset wipes contents so the head reads 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// Entropy harvester: ring-oscillator sampling, optional von Neumann debias and
// LFSR whitening, word packing, repetition-count health test and output FIFO.
module trng_harvester import trng_pkg::*; #(
  parameter int                NUM_RINGS  = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(DEFAULT_LFSR_TAPS),
  parameter int                OUT_W      = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter int                REP_LIMIT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic [NUM_RINGS-1:0]          ring_in,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail
);

  localparam int PACK_W = $clog2(OUT_W);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);
  localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(OUT_W - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(REP_LIMIT);

  mode_e               mode_cur;
  mode_e               mode_q;
  logic [NUM_RINGS-1:0] sync1;
  logic [NUM_RINGS-1:0] sync2;
  logic                raw_bit;
  logic [1:0]          en_d;
  logic                raw_vld;
  logic [LFSR_W-1:0]   lfsr;
  logic                pair_flag;
  logic                pair_first;
  logic [PACK_W-1:0]   pack_cnt;
  logic [OUT_W-1:0]    pack_sr;
  logic                last_raw;
  logic [RUN_W-1:0]    run_cnt;
  logic [RUN_W-1:0]    run_next;

  logic take;
  logic vn_mode;
  logic wht_mode;
  logic mode_chg;
  logic cand_bit;
  logic cand_vld;
  logic bit_out;
  logic bit_in;
  logic word_done;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  assign mode_cur = mode_e'(mode);

  // Datapath selection: which raw bits become packer bits this cycle.
  always_comb begin
    take      = en && raw_vld;
    vn_mode   = (mode_cur == MODE_VN) || (mode_cur == MODE_VN_WHT);
    wht_mode  = (mode_cur == MODE_VN_WHT) || (mode_cur == MODE_RAW_WHT);
    mode_chg  = (mode_cur != mode_q);
    cand_bit  = raw_bit;
    cand_vld  = take;
    if (vn_mode) begin
      cand_bit = pair_first;
      cand_vld = take && pair_flag && (pair_first != raw_bit);
    end
    bit_out   = cand_bit ^ (wht_mode && lfsr[LFSR_W-1]);
    bit_in    = cand_vld && !mode_chg;
    word_done = bit_in && (pack_cnt == PACK_LAST);
    push      = word_done && !health_fail;
    out_valid = !fifo_empty && !health_fail;
    pop       = out_valid && out_ready;
  end

  // Run-length of identical raw bits, saturating at the trip point.
  always_comb begin
    run_next = run_cnt;
    if (raw_bit != last_raw) run_next = RUN_W'(1);
    else if (run_cnt != RUN_MAX) run_next = run_cnt + 1'b1;
  end

  // Two-flop synchroniser followed by the registered XOR reduction.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      raw_bit <= 1'b0;
    end else if (en) begin
      sync1   <= ring_in;
      sync2   <= sync1;
      raw_bit <= xor_reduce(MAX_RINGS'(sync2));
    end
  end

  // Enable delay line marking when raw_bit carries a freshly sampled value.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      en_d    <= '0;
      raw_vld <= 1'b0;
      mode_q  <= MODE_RAW;
    end else begin
      en_d    <= {en_d[0], en};
      raw_vld <= en_d[1];
      mode_q  <= mode_cur;
    end
  end

  // Fibonacci whitening LFSR, advancing every enabled cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) lfsr <= LFSR_W'(1);
    else if (en) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  // Von Neumann pair tracking; a mode switch restarts pairing.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pair_flag  <= 1'b0;
      pair_first <= 1'b0;
    end else if (mode_chg) begin
      pair_flag  <= 1'b0;
    end else if (take && vn_mode) begin
      pair_flag <= !pair_flag;
      if (!pair_flag) pair_first <= raw_bit;
    end
  end

  // Word packer: first bit ends up in the MSB; count restarts even if the word is dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pack_cnt <= '0;
      pack_sr  <= '0;
    end else if (mode_chg) begin
      pack_cnt <= '0;
    end else if (bit_in) begin
      pack_sr  <= {pack_sr[OUT_W-2:0], bit_out};
      pack_cnt <= word_done ? '0 : pack_cnt + 1'b1;
    end
  end

  // Repetition-count health test with a sticky failure flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last_raw    <= 1'b0;
      run_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (take) begin
      last_raw <= raw_bit;
      run_cnt  <= run_next;
      if (run_next == RUN_MAX) health_fail <= 1'b1;
    end
  end

  trng_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pack_sr[OUT_W-2:0], bit_out}),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_trng_harvester.sv
// Scoreboard bench for trng_harvester: directed raw-bit sequences, expected
// words queued up front and checked by an independent output monitor.
module tb_trng_harvester;
  import trng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] ring_in = 4'd0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic       health_fail;

  logic [7:0] sb_q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  trng_harvester #(
    .NUM_RINGS  (4),
    .LFSR_W     (16),
    .LFSR_TAPS  (16'hB400),
    .OUT_W      (8),
    .FIFO_DEPTH (4),
    .REP_LIMIT  (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .ring_in     (ring_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .health_fail (health_fail)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_word: got %0h, expected no word", out_data);
      end else begin
        check_output("word", 32'(out_data), 32'(sb_q.pop_front()));
      end
    end
  end

  // Drive one raw bit per cycle (bit i = seq[63-i]), spread across several rings.
  task automatic apply_stimulus(input mode_e m, input logic [63:0] seq, input int n);
    logic b;
    mode = m;
    for (int i = 0; i < n + 3; i++) begin
      en = 1'b1;
      b  = (i < n) ? seq[63-i] : 1'b0;
      if (i % 2 == 0) ring_in = b ? 4'b0001 : 4'b0011;
      else            ring_in = b ? 4'b1110 : 4'b0000;
      @(posedge clk); #1;
    end
    en = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    out_ready = 1'b0;
    mode = 2'd0;
    ring_in = 4'd0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check_output({tag, "_valid"},  32'(out_valid),   32'd0);
    check_output({tag, "_data"},   32'(out_data),    32'd0);
    check_output({tag, "_level"},  32'(fifo_level),  32'd0);
    check_output({tag, "_health"}, 32'(health_fail), 32'd0);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 100 && sb_q.size() != 0; c++) @(negedge clk);
    check_output(name, 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();
    check_reset_state("cold_reset");

    // Raw mode, alternating 1,0: first bit lands in the MSB.
    apply_stimulus(MODE_RAW, 64'hAA00_0000_0000_0000, 8);
    @(negedge clk);
    check_output("raw_level", 32'(fifo_level), 32'd1);
    check_output("raw_health", 32'(health_fail), 32'd0);
    sb_q.push_back(8'hAA);
    out_ready = 1'b1;
    wait_drain("raw_drain");

    // Von Neumann on 1,0 pairs: every pair yields a 1.
    do_reset();
    sb_q.push_back(8'hFF);
    out_ready = 1'b1;
    apply_stimulus(MODE_VN, 64'hAAAA_0000_0000_0000, 16);
    wait_drain("vn_drain");
    check_output("vn_health", 32'(health_fail), 32'd0);

    // One 0xFF word, then a stuck-at-0 source trips the health test.
    do_reset();
    fork
      apply_stimulus(MODE_VN, 64'hAAAA_0000_0000_0000, 48);
      begin
        repeat (49) @(posedge clk);
        @(negedge clk);
        check_output("health_before", 32'(health_fail), 32'd0);
        check_output("valid_before",  32'(out_valid),   32'd1);
        @(negedge clk);
        check_output("health_trip",   32'(health_fail), 32'd1);
        check_output("valid_blocked", 32'(out_valid),   32'd0);
      end
    join
    check_output("health_level", 32'(fifo_level), 32'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;
    check_output("health_sticky", 32'(health_fail), 32'd1);

    // Overfill: six words offered, four kept, the last two dropped.
    do_reset();
    apply_stimulus(MODE_RAW, 64'h1122_3344_5566_0000, 48);
    @(negedge clk);
    check_output("full_level", 32'(fifo_level), 32'd4);
    check_output("full_head",  32'(out_data),   32'h11);
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    sb_q.push_back(8'h33);
    sb_q.push_back(8'h44);
    out_ready = 1'b1;
    wait_drain("full_drain");
    @(negedge clk);
    check_output("drained_level", 32'(fifo_level), 32'd0);

    // Raw + whitening on a zero source: words follow the LFSR MSB from seed 1.
    do_reset();
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h08);
    sb_q.push_back(8'h01);
    out_ready = 1'b1;
    apply_stimulus(MODE_RAW_WHT, 64'h0, 24);
    wait_drain("wht_drain");

    // Warm reset mid-word with two words stored, then a clean restart.
    do_reset();
    apply_stimulus(MODE_RAW, 64'h1122_A000_0000_0000, 20);
    @(negedge clk);
    check_output("warm_level_before", 32'(fifo_level), 32'd2);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    mode = 2'd0;
    check_reset_state("warm_reset");
    @(posedge clk); #1;
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h08);
    out_ready = 1'b1;
    apply_stimulus(MODE_RAW_WHT, 64'h0, 16);
    wait_drain("restart_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trng_harvester.md
# trng_harvester

Parametrised entropy harvester for the TRNG path. It samples NUM_RINGS free-running ring-oscillator outputs and XOR-reduces them to one raw bit per cycle. The raw stream is optionally von Neumann debiased and LFSR-whitened, then packed into OUT_W-bit words and buffered in a small FIFO behind a valid/ready output port. A sticky repetition-count health test blocks output when the source is stuck.

## Interface
Parameters:
- NUM_RINGS, 4: number of ring-oscillator inputs.
- LFSR_W, 16: whitening LFSR width (≥ 4).
- LFSR_TAPS, 16'hB400: Fibonacci feedback mask, bit i = tap on stage i+1; default taps 16,14,13,11.
- OUT_W, 8: output word width (2..32).
- FIFO_DEPTH, 4: output FIFO depth in words (power of two, ≥ 2).
- REP_LIMIT, 32: run length of identical raw bits that trips the health test (≥ 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-high; clock clk.
- en  in  1  harvest enable; when low, the whole pipeline holds its state.
- mode  in  2  0 = raw, 1 = von Neumann, 2 = von Neumann + LFSR XOR, 3 = raw + LFSR XOR.
- ring_in  in  NUM_RINGS  asynchronous ring outputs.
- out_data  out  OUT_W  head word of the FIFO.
- out_valid  out  1  FIFO not empty and health_fail low.
- out_ready  in  1  consumer accepts a word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- health_fail  out  1  sticky repetition-count failure.

## Operation
- Reset values: every output is 0; LFSR = 1; sync/pair/packer/run-counter state cleared.
- Sampling: each ring_in bit passes through a 2-flop synchroniser. The synchronised vector is XOR-reduced and registered as raw_bit, with raw_vld = en delayed by 3 cycles.
- Debias (modes 1, 2):
  - Consecutive raw bits form non-overlapping pairs.
  - 01 → 0 and 10 → 1, both valid.
  - 00 and 11 are discarded.
  - A pair flag tracks first or second bit of the pair.
- Whitening (modes 2, 3):
  - The LFSR shifts once per cycle while en is high.
  - The output bit is the candidate bit XOR the LFSR MSB.
- Packer:
  - Each valid bit is shifted in at the LSB, so the first bit lands in the MSB.
  - After OUT_W bits, the word is pushed and the bit count returns to 0.
  - If the FIFO is full at push time, the word is dropped and the count still resets.
- FIFO:
  - Pop occurs when out_valid && out_ready.
  - A simultaneous push and pop while full is legal: the level is unchanged and no word is dropped.
  - A simultaneous push and pop while empty is impossible, because out_valid is low when empty.
- Health test:
  - A run counter counts consecutive identical raw bits. It resets to 1 when raw_bit differs from the previous raw bit.
  - When the counter reaches REP_LIMIT, health_fail is set. It stays set until reset.
  - While health_fail is high: pushes are suppressed and out_valid = 0. FIFO contents are retained but not observable as valid.
- Mode change (any cycle where mode differs from its registered copy): pair flag and packer count clear next cycle; the FIFO is untouched.
- en low: synchroniser, LFSR, pair flag, packer and run counter all hold. The FIFO output port still operates.

## Timing
- ring_in to raw_bit: 3 cycles (2 sync + 1 reduce register).
- Mode 0: first word is pushed 3 + OUT_W cycles after en rises with steady input. out_valid rises the cycle after the push.
- Modes 1/2: throughput is at most 1 bit per 2 cycles; latency depends on the data.
- health_fail asserts on the cycle the run counter reaches REP_LIMIT. out_valid drops in that same cycle.
- out_data and out_valid are registered (FIFO read side); out_data is stable while out_valid && !out_ready.
- Reset during operation clears all state asynchronously, including FIFO contents.

## Structure
- Package trng_pkg holds:
  - the mode_e enum (MODE_RAW, MODE_VN, MODE_VN_WHT, MODE_RAW_WHT);
  - the default LFSR_TAPS constant;
  - a function for the XOR reduction.
- Sub-module trng_fifo: a parametrised synchronous FIFO (width, depth) with push, pop, full, empty and level.
- The synchroniser, debias, LFSR, packer and health test stay in trng_harvester.

## Test plan
- Mode 0, OUT_W = 8, ring_in = 4'b0001 then 4'b0011 alternating every cycle (raw 1,0,1,0…) → the first word is 8'hAA, fifo_level increments to 1, and health_fail stays 0.
- Mode 1 with the same alternating stream (pairs 10) → every pair yields 1. After 16 raw bits, out_data = 8'hFF.
- Mode 1, ring_in constant 0 → no words are pushed. health_fail rises exactly 32 cycles after raw_bit first becomes 0, and out_valid stays 0.
- Fill the FIFO with out_ready = 0 in mode 0 → fifo_level saturates at 4 and further words are dropped. Then hold out_ready = 1 → the four oldest words drain in order.
- Mode 3, ring_in constant 4'b0000 with REP_LIMIT = 64 → output words equal the LFSR MSB sequence from seed 1 (the first word is checked against the reference model).
- Assert rst_n for 1 cycle mid-word with the FIFO holding 2 words → all outputs are 0 and fifo_level = 0. Restart gives a first word identical to the one after a cold reset.
